menu_sprite_sequencer: RTL and testbench
========================================

// Module: menu_sprite_sequencer
// PURPOSE
//  Pixel-domain read sequencer for the two-image menu sprite ROM (two 5-bit palette-index planes, shared 19-bit address).
//  Converts VGA scan position into ROM read addresses using a per-frame row-base counter; no multiplier.
//  Alternates menu image 0/1 every TOGGLE_FRAMES frames and delivers a pipelined, window-qualified palette index to colour mapping.
// PARAMETERS
//  IMG_W          450  sprite width in pixels
//  IMG_H          370  sprite height in pixels
//  X0             95   screen x of sprite left column
//  Y0             55   screen y of sprite top row
//  ADDR_W         19   ROM address width; must hold IMG_W*IMG_H-1
//  IDX_W          5    palette index width
//  TOGGLE_FRAMES  30   frames per image before flipping (>=1)
// PORTS
//  pixel_clk    in   1       pixel clock; only clock
//  reset_n      in   1       synchronous active-low reset
//  draw_x       in   10      current scan x from VGA controller
//  draw_y       in   10      current scan y from VGA controller
//  vde          in   1       active-video flag
//  frame_start  in   1       one-cycle pulse at start of each frame
//  menu_en      in   1       menu layer enable
//  anim_en      in   1       image alternation enable
//  rom_addr     out  ADDR_W  ROM read address (registered)
//  rom_data0    in   IDX_W   ROM image 0 data (async read of rom_addr)
//  rom_data1    in   IDX_W   ROM image 1 data (async read of rom_addr)
//  pix_idx      out  IDX_W   selected palette index, registered
//  pix_valid    out  1       pix_idx is a sprite pixel
//  frame_sel    out  1       image currently displayed
//  sync_err     out  1       sticky: frame ended with partial sprite scan
// BEHAVIOUR
//  Reset (reset_n=0 at edge): rom_addr=0, pix_idx=0, pix_valid=0, frame_sel=0, sync_err=0, row_base=0, frame_cnt=0, pipe cleared.
//  S0 (comb): in_win = menu_en & vde & X0<=draw_x<X0+IMG_W & Y0<=draw_y<Y0+IMG_H.
//  S1 (reg): rom_addr <= in_win ? row_base+(draw_x-X0) : 0; v1<=in_win; sel1<=frame_sel.
//  S2 (reg): pix_idx <= v1 ? (sel1 ? rom_data1 : rom_data0) : 0; pix_valid<=v1.
//  Latency: draw_x/draw_y -> rom_addr 1 cycle; -> pix_idx/pix_valid 2 cycles. Full throughput, one pixel/cycle.
//  row_base: += IMG_W on cycle where in_win & draw_x==X0+IMG_W-1; cleared on frame_start.
//  frame_start same cycle as row increment: clear wins (row_base=0).
//  Address range: 0..IMG_W*IMG_H-1 only; row_base never wraps past IMG_W*IMG_H.
//  sync_err: set on frame_start if row_base not in {0, IMG_W*IMG_H}; held until reset.
//  Animation: on frame_start with anim_en&menu_en: frame_cnt==TOGGLE_FRAMES-1 -> frame_cnt=0, frame_sel flips; else frame_cnt++.
//  anim_en=0: frame_cnt and frame_sel hold. menu_en=0: frame_cnt=0, frame_sel=0 next cycle.
//  frame_sel changes only at frame_start (or menu_en drop): no mid-frame image tearing; S1 snapshot keeps in-flight pixels consistent.
//  menu_en deassert mid-frame: new pixels invalid from next cycle; in-flight pixels drain normally.
//  Reset mid-frame: all state cleared; next valid pixel requires frame_start to realign row_base.
// TESTING
//  Scan (95,55) -> rom_addr=0 at +1, pix_idx=rom_data0[0], pix_valid=1 at +2.
//  (544,55)->449; (95,56)->450; (544,424)->166499; (94,55),(545,55),(95,425) -> pix_valid=0, rom_addr=0.
//  Full-frame scan x2 -> sync_err=0; frame_start after 100 sprite rows -> sync_err=1, sticky.
//  anim_en=1, 30 frame_start pulses -> frame_sel 0->1 on 30th, pix_idx from rom_data1; 60 -> back to 0.
//  anim_en=0 for 10 frames -> frame_sel/frame_cnt held; menu_en=0 -> frame_sel=0, pix_valid=0 within 2 cycles.
//  frame_start coincident with x=544 row-end; reset_n=0 mid-scan -> row_base=0, all outputs 0 next edge.

Source files
------------

// File: rtl/menu_sprite_sequencer.sv
// Pixel-domain read sequencer for the two-image menu sprite ROM.
// Turns scan position into ROM addresses via a per-frame row-base counter and alternates images.
module menu_sprite_sequencer #(
  parameter int unsigned IMG_W         = 450,
  parameter int unsigned IMG_H         = 370,
  parameter int unsigned X0            = 95,
  parameter int unsigned Y0            = 55,
  parameter int unsigned ADDR_W        = 19,
  parameter int unsigned IDX_W         = 5,
  parameter int unsigned TOGGLE_FRAMES = 30,
  parameter int unsigned COORD_W       = 10
) (
  input  logic               pixel_clk,
  input  logic               reset_n,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  input  logic               vde,
  input  logic               frame_start,
  input  logic               menu_en,
  input  logic               anim_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [IDX_W-1:0]   rom_data0,
  input  logic [IDX_W-1:0]   rom_data1,
  output logic [IDX_W-1:0]   pix_idx,
  output logic               pix_valid,
  output logic               frame_sel,
  output logic               sync_err
);

  localparam int unsigned CNT_W = (TOGGLE_FRAMES > 1) ? $clog2(TOGGLE_FRAMES) : 1;

  localparam logic [COORD_W-1:0] X_LO     = COORD_W'(X0);
  localparam logic [COORD_W-1:0] X_HI     = COORD_W'(X0 + IMG_W - 1);
  localparam logic [COORD_W-1:0] Y_LO     = COORD_W'(Y0);
  localparam logic [COORD_W-1:0] Y_HI     = COORD_W'(Y0 + IMG_H - 1);
  localparam logic [ADDR_W-1:0]  ROW_STEP = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0]  TOTAL    = ADDR_W'(IMG_W * IMG_H);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TOGGLE_FRAMES - 1);

  logic [ADDR_W-1:0]  r_rom_addr;
  logic               r_v1;
  logic               r_sel1;
  logic [IDX_W-1:0]   r_pix_idx;
  logic               r_pix_valid;
  logic [ADDR_W-1:0]  r_row_base;
  logic [CNT_W-1:0]   r_frame_cnt;
  logic               r_frame_sel;
  logic               r_sync_err;

  logic               w_in_win;
  logic [COORD_W-1:0] w_x_off;
  logic [ADDR_W-1:0]  w_addr_nxt;
  logic [IDX_W-1:0]   w_pix_nxt;
  logic [ADDR_W-1:0]  w_row_base_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_sel_nxt;
  logic               w_err_nxt;

  // Sprite window qualification of the current scan position
  assign w_in_win = menu_en & vde
                  & (draw_x >= X_LO) & (draw_x <= X_HI)
                  & (draw_y >= Y_LO) & (draw_y <= Y_HI);
  assign w_x_off  = draw_x - X_LO;

  always_comb begin
    w_addr_nxt     = '0;
    w_pix_nxt      = '0;
    w_row_base_nxt = r_row_base;
    w_cnt_nxt      = r_frame_cnt;
    w_sel_nxt      = r_frame_sel;
    w_err_nxt      = r_sync_err;

    if (w_in_win && (r_row_base < TOTAL)) begin
      w_addr_nxt = r_row_base + ADDR_W'(w_x_off);
    end

    if (r_v1) begin
      w_pix_nxt = r_sel1 ? rom_data1 : rom_data0;
    end

    // Frame start realigns the row base; clearing beats a coincident row-end step
    if (frame_start) begin
      w_row_base_nxt = '0;
      if ((r_row_base != '0) && (r_row_base != TOTAL)) begin
        w_err_nxt = 1'b1;
      end
    end else if (w_in_win && (draw_x == X_HI) && (r_row_base < TOTAL)) begin
      w_row_base_nxt = r_row_base + ROW_STEP;
    end

    // Image selection only moves at frame boundaries or when the layer is disabled
    if (!menu_en) begin
      w_cnt_nxt = '0;
      w_sel_nxt = 1'b0;
    end else if (frame_start && anim_en) begin
      if (r_frame_cnt == CNT_LAST) begin
        w_cnt_nxt = '0;
        w_sel_nxt = ~r_frame_sel;
      end else begin
        w_cnt_nxt = r_frame_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      r_rom_addr  <= '0;
      r_v1        <= 1'b0;
      r_sel1      <= 1'b0;
      r_pix_idx   <= '0;
      r_pix_valid <= 1'b0;
      r_row_base  <= '0;
      r_frame_cnt <= '0;
      r_frame_sel <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_rom_addr  <= w_addr_nxt;
      r_v1        <= w_in_win;
      r_sel1      <= r_frame_sel;
      r_pix_idx   <= w_pix_nxt;
      r_pix_valid <= r_v1;
      r_row_base  <= w_row_base_nxt;
      r_frame_cnt <= w_cnt_nxt;
      r_frame_sel <= w_sel_nxt;
      r_sync_err  <= w_err_nxt;
    end
  end

  assign rom_addr  = r_rom_addr;
  assign pix_idx   = r_pix_idx;
  assign pix_valid = r_pix_valid;
  assign frame_sel = r_frame_sel;
  assign sync_err  = r_sync_err;

endmodule

// File: tb/tb_menu_sprite_sequencer.sv
// Bench for menu_sprite_sequencer: per-cycle comparison against a row-count/frame-count model
// plus directed literal expectations.
module tb_menu_sprite_sequencer;

  localparam int IMG_W = 450;
  localparam int IMG_H = 370;
  localparam int X0    = 95;
  localparam int Y0    = 55;
  localparam int TF    = 30;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  draw_x;
  logic [9:0]  draw_y;
  logic        vde;
  logic        frame_start;
  logic        menu_en;
  logic        anim_en;
  logic [18:0] rom_addr;
  logic [4:0]  rom_data0;
  logic [4:0]  rom_data1;
  logic [4:0]  pix_idx;
  logic        pix_valid;
  logic        frame_sel;
  logic        sync_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  menu_sprite_sequencer dut (
    .pixel_clk   (clk),
    .reset_n     (reset_n),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .vde         (vde),
    .frame_start (frame_start),
    .menu_en     (menu_en),
    .anim_en     (anim_en),
    .rom_addr    (rom_addr),
    .rom_data0   (rom_data0),
    .rom_data1   (rom_data1),
    .pix_idx     (pix_idx),
    .pix_valid   (pix_valid),
    .frame_sel   (frame_sel),
    .sync_err    (sync_err)
  );

  function automatic logic [4:0] rom0(input logic [18:0] a);
    return a[4:0] ^ a[9:5] ^ 5'h15;
  endfunction

  function automatic logic [4:0] rom1(input logic [18:0] a);
    return a[4:0] ^ a[14:10] ^ 5'h1F;
  endfunction

  assign rom_data0 = rom0(rom_addr);
  assign rom_data1 = rom1(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: sprite rows completed this frame and enabled frame_start count
  int m_rows, m_frames, m_addr, m_pix;
  bit m_err, m_v1, m_s1, m_pv, m_live, m_win;

  function automatic bit sel_of(input int frames);
    return ((frames / TF) % 2) == 1;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_rows = 0; m_frames = 0; m_addr = 0; m_pix = 0;
      m_err = 0; m_v1 = 0; m_s1 = 0; m_pv = 0; m_live = 1;
    end else begin
      m_win = menu_en && vde && int'(draw_x) >= X0 && int'(draw_x) < X0 + IMG_W
              && int'(draw_y) >= Y0 && int'(draw_y) < Y0 + IMG_H;
      m_pv  = m_v1;
      m_pix = m_v1 ? int'(m_s1 ? rom1(19'(m_addr)) : rom0(19'(m_addr))) : 0;
      m_addr = (m_win && m_rows < IMG_H) ? m_rows * IMG_W + int'(draw_x) - X0 : 0;
      m_v1  = m_win;
      m_s1  = sel_of(m_frames);
      if (frame_start && m_rows != 0 && m_rows != IMG_H) m_err = 1;
      if (frame_start) m_rows = 0;
      else if (m_win && int'(draw_x) == X0 + IMG_W - 1 && m_rows < IMG_H) m_rows++;
      if (!menu_en) m_frames = 0;
      else if (frame_start && anim_en) m_frames++;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("cyc_rom_addr", 32'(rom_addr), 32'(m_addr));
      check("cyc_pix_idx", 32'(pix_idx), 32'(m_pix));
      check("cyc_pix_valid", 32'(pix_valid), 32'(m_pv));
      check("cyc_frame_sel", 32'(frame_sel), 32'(sel_of(m_frames)));
      check("cyc_sync_err", 32'(sync_err), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic px(input int x, input int y, input bit v, input bit fs);
    draw_x = 10'(x); draw_y = 10'(y); vde = v; frame_start = fs;
    tick();
  endtask

  task automatic pulse_fs();
    px(0, 0, 1'b0, 1'b1);
  endtask

  task automatic scan_rows(input int first, input int n);
    for (int r = 0; r < n; r++) begin
      px(X0 + IMG_W - 2, first + r, 1'b1, 1'b0);
      px(X0 + IMG_W - 1, first + r, 1'b1, 1'b0);
    end
    px(0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; menu_en = 1'b0; anim_en = 1'b0;
    draw_x = '0; draw_y = '0; vde = 1'b0; frame_start = 1'b0;
    tick(); tick();
    check("rst_addr", 32'(rom_addr), 0);
    check("rst_pix", 32'(pix_idx), 0);
    check("rst_valid", 32'(pix_valid), 0);
    check("rst_sel", 32'(frame_sel), 0);
    check("rst_err", 32'(sync_err), 0);

    reset_n = 1'b1; menu_en = 1'b1;
    pulse_fs();
    px(95, 55, 1'b1, 1'b0);
    check("addr_first", 32'(rom_addr), 0);
    px(544, 55, 1'b1, 1'b0);
    check("pix_first_valid", 32'(pix_valid), 1);
    check("pix_first_idx", 32'(pix_idx), 21);
    check("addr_row_end", 32'(rom_addr), 449);
    px(95, 56, 1'b1, 1'b0);
    check("addr_row1", 32'(rom_addr), 450);
    px(94, 55, 1'b1, 1'b0);
    check("addr_left_out", 32'(rom_addr), 0);
    px(545, 55, 1'b1, 1'b0);
    check("addr_right_out", 32'(rom_addr), 0);
    check("valid_left_out", 32'(pix_valid), 0);
    px(95, 425, 1'b1, 1'b0);
    check("addr_below_out", 32'(rom_addr), 0);
    check("valid_right_out", 32'(pix_valid), 0);
    px(0, 0, 1'b0, 1'b0);
    check("valid_below_out", 32'(pix_valid), 0);

    scan_rows(56, 368);
    px(544, 424, 1'b1, 1'b0);
    check("addr_last", 32'(rom_addr), 166499);
    pulse_fs();
    check("serr_full0", 32'(sync_err), 0);
    scan_rows(55, IMG_H); pulse_fs();
    scan_rows(55, IMG_H); pulse_fs();
    check("serr_full2", 32'(sync_err), 0);
    scan_rows(55, 100); pulse_fs();
    check("serr_partial", 32'(sync_err), 1);
    scan_rows(55, IMG_H); pulse_fs();
    check("serr_sticky", 32'(sync_err), 1);

    anim_en = 1'b1;
    repeat (29) pulse_fs();
    check("anim_29", 32'(frame_sel), 0);
    pulse_fs();
    check("anim_30", 32'(frame_sel), 1);
    px(95, 55, 1'b1, 1'b0);
    px(0, 0, 1'b0, 1'b0);
    check("img1_valid", 32'(pix_valid), 1);
    check("img1_idx", 32'(pix_idx), 31);
    repeat (30) pulse_fs();
    check("anim_60", 32'(frame_sel), 0);

    repeat (5) pulse_fs();
    anim_en = 1'b0;
    repeat (10) pulse_fs();
    check("hold_sel", 32'(frame_sel), 0);
    anim_en = 1'b1;
    repeat (24) pulse_fs();
    check("hold_cnt_24", 32'(frame_sel), 0);
    pulse_fs();
    check("hold_cnt_25", 32'(frame_sel), 1);

    px(95, 55, 1'b1, 1'b0);
    menu_en = 1'b0;
    px(96, 55, 1'b1, 1'b0);
    check("menu_off_sel", 32'(frame_sel), 0);
    check("menu_off_drain", 32'(pix_valid), 1);
    px(97, 55, 1'b1, 1'b0);
    check("menu_off_valid", 32'(pix_valid), 0);
    menu_en = 1'b1;
    px(0, 0, 1'b0, 1'b0);

    pulse_fs();
    scan_rows(55, 3);
    px(544, 58, 1'b1, 1'b1);
    px(95, 59, 1'b1, 1'b0);
    check("fs_clear_wins", 32'(rom_addr), 0);
    px(0, 0, 1'b0, 1'b0);

    scan_rows(55, 2);
    px(300, 57, 1'b1, 1'b0);
    reset_n = 1'b0;
    px(301, 57, 1'b1, 1'b0);
    check("midrst_addr", 32'(rom_addr), 0);
    check("midrst_pix", 32'(pix_idx), 0);
    check("midrst_valid", 32'(pix_valid), 0);
    check("midrst_sel", 32'(frame_sel), 0);
    check("midrst_err", 32'(sync_err), 0);
    reset_n = 1'b1;
    pulse_fs();
    px(96, 55, 1'b1, 1'b0);
    check("post_rst_addr", 32'(rom_addr), 1);
    px(0, 0, 1'b0, 1'b0);
    px(0, 0, 1'b0, 1'b0);
    px(0, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
